ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_arb_pkg.sv | 15 +
 rtl/ram_arb_pick.sv | 34 +++
 rtl/ram_port_arbiter.sv | 125 ++++++++++++
 tb/tb_ram_port_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared widths and FSM state encoding for the two-port RAM arbiter.
// Optional build macro: RAM_ARB_FIXED_PRIO_EN (see ram_arb_pick).
package ram_arb_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int N_REQ  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDATA  = 2'd2
    } state_e;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner select for the RAM arbiter.
// RAM_ARB_FIXED_PRIO_EN: requester 0 wins ties; otherwise round-robin.
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic             last_i,
    output logic             vld_o,
    output logic             win_o
);

    logic tie_win;

`ifdef RAM_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = last_i;
    assign tie_win     = 1'b0;
`else
    // The requester not granted last time takes the tie.
    assign tie_win = ~last_i;
`endif

    always_comb begin
        vld_o = |req_i;
        win_o = 1'b0;
        unique case (1'b1)
            (req_i == 2'b11): win_o = tie_win;
            (req_i == 2'b10): win_o = 1'b1;
            (req_i == 2'b01): win_o = 1'b0;
            default:          win_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous RAM.
// Build option RAM_ARB_FIXED_PRIO_EN selects fixed priority on ties.
module ram_port_arbiter
    import ram_arb_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        req_we,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    busy,
    output logic [ADDR_W-1:0]       ram_address,
    output logic [DATA_W-1:0]       ram_data_in,
    output logic                    ram_write_enable,
    output logic                    ram_read_enable,
    input  logic [DATA_W-1:0]       ram_data_out
);

    state_e              state_q;
    logic                win_q;
    logic                we_q;
    logic                last_q;
    logic [N_REQ-1:0]    gnt_q;
    logic [N_REQ-1:0]    rd_valid_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic                busy_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic [DATA_W-1:0]   ram_din_q;
    logic                ram_we_q;
    logic                ram_re_q;

    logic                pick_vld;
    logic                pick_win;
    logic                we_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wdata_d;

    ram_arb_pick u_pick (
        .req_i  (req),
        .last_i (last_q),
        .vld_o  (pick_vld),
        .win_o  (pick_win)
    );

    always_comb begin
        we_d    = req_we[pick_win];
        addr_d  = pick_win ? req_addr[2*ADDR_W-1:ADDR_W]
                           : req_addr[ADDR_W-1:0];
        wdata_d = pick_win ? req_wdata[2*DATA_W-1:DATA_W]
                           : req_wdata[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            win_q      <= 1'b0;
            we_q       <= 1'b0;
            // Pointer at 1 so requester 0 wins the first tie.
            last_q     <= 1'b1;
            gnt_q      <= '0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
            busy_q     <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            ram_we_q   <= 1'b0;
            ram_re_q   <= 1'b0;
        end else begin
            gnt_q      <= '0;
            rd_valid_q <= '0;
            ram_we_q   <= 1'b0;
            ram_re_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        state_q         <= ACCESS;
                        busy_q          <= 1'b1;
                        win_q           <= pick_win;
                        we_q            <= we_d;
                        last_q          <= pick_win;
                        gnt_q[pick_win] <= 1'b1;
                        ram_addr_q      <= addr_d;
                        ram_din_q       <= wdata_d;
                        ram_we_q        <= we_d;
                        ram_re_q        <= ~we_d;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (we_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= RDATA;
                    end
                end
                RDATA: begin
                    rd_data_q         <= ram_data_out;
                    rd_valid_q[win_q] <= 1'b1;
                    state_q           <= IDLE;
                    busy_q            <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt              = gnt_q;
    assign rd_valid         = rd_valid_q;
    assign rd_data          = rd_data_q;
    assign busy             = busy_q;
    assign ram_address      = ram_addr_q;
    assign ram_data_in      = ram_din_q;
    assign ram_write_enable = ram_we_q;
    assign ram_read_enable  = ram_re_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural 32x8 RAM.
// Tie expectations follow RAM_ARB_FIXED_PRIO_EN when defined.
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [1:0]  req_we;
    logic [9:0]  req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  gnt;
    logic [1:0]  rd_valid;
    logic [7:0]  rd_data;
    logic        busy;
    logic [4:0]  ram_address;
    logic [7:0]  ram_data_in;
    logic        ram_write_enable;
    logic        ram_read_enable;
    logic [7:0]  ram_data_out;

    logic [7:0]  mem [32];
    logic        pre_we;
    logic [4:0]  pre_a;
    logic [7:0]  pre_d;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_port_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .req              (req),
        .req_we           (req_we),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .gnt              (gnt),
        .rd_valid         (rd_valid),
        .rd_data          (rd_data),
        .busy             (busy),
        .ram_address      (ram_address),
        .ram_data_in      (ram_data_in),
        .ram_write_enable (ram_write_enable),
        .ram_read_enable  (ram_read_enable),
        .ram_data_out     (ram_data_out)
    );

    always @(posedge clk) begin
        if (pre_we)
            mem[pre_a] <= pre_d;
        if (ram_write_enable)
            mem[ram_address] <= ram_data_in;
        if (ram_read_enable)
            ram_data_out <= mem[ram_address];
    end

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_req(input int r, input logic we,
                           input logic [4:0] a, input logic [7:0] d);
        req_we[r]          = we;
        req_addr[r*5 +: 5] = a;
        req_wdata[r*8 +: 8] = d;
        req[r]             = 1'b1;
    endtask

    task automatic xact(input int r, input logic we, input logic [4:0] a,
                        input logic [7:0] d, input logic [7:0] exp_rd,
                        input string tag);
        set_req(r, we, a, d);
        tick();
        chk({tag, "_gnt"}, 32'(gnt), 32'(1 << r));
        req[r] = 1'b0;
        tick();
        if (!we) begin
            tick();
            chk({tag, "_vld"}, 32'(rd_valid), 32'(1 << r));
            chk({tag, "_rd"}, 32'(rd_data), 32'(exp_rd));
        end
    endtask

    task automatic wait_gnt(input string tag, output logic [1:0] g);
        int n;
        n = 0;
        g = '0;
        while (n < 6 && g == 2'b00) begin
            tick();
            g = gnt;
            n++;
        end
        chk({tag, "_timeout"}, 32'(g == 2'b00), 32'd0);
    endtask

    initial begin
        logic [1:0] g;
        int         exp_w;
        reset     = 1'b1;
        req       = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        pre_we    = 1'b0;
        pre_a     = '0;
        pre_d     = '0;
        do_reset();

        chk("rst_gnt",  32'(gnt), 32'd0);
        chk("rst_vld",  32'(rd_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_we",   32'(ram_write_enable), 32'd0);
        chk("rst_re",   32'(ram_read_enable), 32'd0);
        chk("rst_addr", 32'(ram_address), 32'd0);
        chk("rst_din",  32'(ram_data_in), 32'd0);
        chk("rst_rd",   32'(rd_data), 32'd0);

        // single write then read, requester 0
        set_req(0, 1'b1, 5'd3, 8'hA5);
        tick();
        chk("w_gnt",  32'(gnt), 32'h1);
        chk("w_we",   32'(ram_write_enable), 32'h1);
        chk("w_re",   32'(ram_read_enable), 32'h0);
        chk("w_addr", 32'(ram_address), 32'h3);
        chk("w_din",  32'(ram_data_in), 32'hA5);
        chk("w_busy", 32'(busy), 32'h1);
        req[0] = 1'b0;
        tick();
        chk("w_idle_gnt",  32'(gnt), 32'h0);
        chk("w_idle_busy", 32'(busy), 32'h0);
        chk("w_idle_we",   32'(ram_write_enable), 32'h0);
        set_req(0, 1'b0, 5'd3, 8'h00);
        tick();
        chk("r_gnt", 32'(gnt), 32'h1);
        chk("r_re",  32'(ram_read_enable), 32'h1);
        chk("r_we",  32'(ram_write_enable), 32'h0);
        req[0] = 1'b0;
        tick();
        chk("r_rdata_busy", 32'(busy), 32'h1);
        chk("r_rdata_vld",  32'(rd_valid), 32'h0);
        chk("r_rdata_re",   32'(ram_read_enable), 32'h0);
        tick();
        chk("r_vld",  32'(rd_valid), 32'h1);
        chk("r_rd",   32'(rd_data), 32'hA5);
        chk("r_busy", 32'(busy), 32'h0);
        tick();
        chk("r_vld_pulse", 32'(rd_valid), 32'h0);
        chk("r_rd_hold",   32'(rd_data), 32'hA5);

        // contention: both requesters write continuously
        do_reset();
        set_req(0, 1'b1, 5'd1, 8'h11);
        set_req(1, 1'b1, 5'd2, 8'h22);
        for (int k = 0; k < 4; k++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            exp_w = 0;
`else
            exp_w = k % 2;
`endif
            wait_gnt("cont", g);
            chk("cont_gnt", 32'(g), 32'(1 << exp_w));
        end
        req[0] = 1'b0;
        wait_gnt("cont_tail", g);
        chk("cont_tail_gnt", 32'(g), 32'h2);
        req = '0;
        tick();
        tick();
        chk("cont_mem1", 32'(mem[1]), 32'h11);
        chk("cont_mem2", 32'(mem[2]), 32'h22);

        // read/write interleave on addr 7
        do_reset();
        pre_we = 1'b1;
        pre_a  = 5'd7;
        pre_d  = 8'h3C;
        tick();
        pre_we = 1'b0;
        set_req(0, 1'b0, 5'd7, 8'h00);
        set_req(1, 1'b1, 5'd7, 8'h5A);
        tick();
        chk("il_gnt0", 32'(gnt), 32'h1);
        req[0] = 1'b0;
        tick();
        tick();
        chk("il_vld", 32'(rd_valid), 32'h1);
        chk("il_rd",  32'(rd_data), 32'h3C);
        tick();
        chk("il_gnt1", 32'(gnt), 32'h2);
        chk("il_we",   32'(ram_write_enable), 32'h1);
        req[1] = 1'b0;
        tick();
        xact(0, 1'b0, 5'd7, 8'h00, 8'h5A, "il_rb");

        // reset during RDATA aborts the read
        set_req(0, 1'b0, 5'd7, 8'h00);
        tick();
        chk("ra_gnt", 32'(gnt), 32'h1);
        req[0] = 1'b0;
        tick();
        chk("ra_busy", 32'(busy), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("ra_vld",  32'(rd_valid), 32'h0);
        chk("ra_bsy0", 32'(busy), 32'h0);
        chk("ra_g0",   32'(gnt), 32'h0);
        chk("ra_rd0",  32'(rd_data), 32'h0);
        chk("ra_addr", 32'(ram_address), 32'h0);
        chk("ra_re",   32'(ram_read_enable), 32'h0);
        tick();
        chk("ra_vld2", 32'(rd_valid), 32'h0);
        xact(1, 1'b1, 5'd9, 8'h77, 8'h00, "ra_w");
        xact(0, 1'b0, 5'd9, 8'h00, 8'h77, "ra_r");

        // full sweep: r1 writes, r0 reads back
        for (int a = 0; a < 32; a++)
            xact(1, 1'b1, 5'(a), 8'(a ^ 8'h55), 8'h00, "sw_w");
        for (int a = 0; a < 32; a++)
            xact(0, 1'b0, 5'(a), 8'h00, 8'(a ^ 8'h55), "sw_r");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
